// File: rtl/subpel_pkg.sv
// Shared geometry for the reference-window path (loader and subpixel_interpolation).
// All widths derive from pixel size, window dimension and beat width.
package subpel_pkg;
    localparam int PIX_W         = 8;
    localparam int WIN_DIM       = 15;
    localparam int BEAT_PIX      = 8;
    localparam int BEATS_PER_ROW = (WIN_DIM + BEAT_PIX - 1) / BEAT_PIX;
    localparam int BEATS_PER_WIN = WIN_DIM * BEATS_PER_ROW;
    localparam int ROW_BITS      = PIX_W * WIN_DIM;
    localparam int WIN_BITS      = ROW_BITS * WIN_DIM;
    localparam int BEAT_BITS     = PIX_W * BEAT_PIX;
    localparam int CNT_W         = $clog2(BEATS_PER_WIN);

    typedef logic [CNT_W-1:0]     beat_cnt_t;
    typedef logic [BEAT_BITS-1:0] beat_t;
    typedef logic [WIN_BITS-1:0]  window_t;
endpackage

// File: rtl/ref_window_loader_if.sv
// Valid/ready stream with start-of-frame marker; width set per use (beat or whole window).
interface ref_window_loader_if #(
    parameter int W = subpel_pkg::BEAT_BITS
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         sof;

    modport master (output data, valid, sof, input  ready);
    modport slave  (input  data, valid, sof, output ready);
endinterface

// File: rtl/ref_window_loader_window_out_reg.sv
// Window-wide valid/ready register slice: loads a staged window when the output is empty
// or being drained in the same cycle, and holds it stable under backpressure.
module window_out_reg
    import subpel_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  window_t stage_data,
    input  logic    stage_full,
    output logic    stage_take,
    output window_t out_buffer,
    output logic    out_valid,
    input  logic    out_ready
);
    assign stage_take = stage_full && (!out_valid || out_ready);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_buffer <= '0;
        end else if (stage_take) begin
            out_buffer <= stage_data;
            out_valid  <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: rtl/ref_window_loader.sv
// Assembles 30 eight-pixel beats into a 15x15 pixel window; a staging copy fills while
// the previous window is held in the output slice.
module ref_window_loader
    import subpel_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    ref_window_loader_if.slave  in_bus,
    ref_window_loader_if.master out_bus,
    output logic                sof_err
);
    beat_cnt_t beat_cnt;
    beat_cnt_t wr_cnt;
    logic      stage_full;
    logic      stage_take;
    logic      accept;
    logic      win_done;
    window_t   stage;
    int        row_idx;
    int        col_base;

    assign in_bus.ready = !rst && !stage_full;
    assign accept       = in_bus.valid && in_bus.ready;

    // A start-of-frame beat always lands in slot 0, restarting any partial window.
    // NOTE: defaults are assigned first so no path leaves a variable unassigned (no latch).
    always_comb begin
        wr_cnt = beat_cnt;
        if (in_bus.sof) wr_cnt = '0;
        row_idx  = int'(wr_cnt) / BEATS_PER_ROW;
        col_base = (int'(wr_cnt) % BEATS_PER_ROW) * BEAT_PIX;
    end

    assign win_done = (wr_cnt == beat_cnt_t'(BEATS_PER_WIN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            stage_full <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            sof_err <= accept && in_bus.sof && (beat_cnt != '0);
            if (accept) beat_cnt <= win_done ? '0 : beat_cnt_t'(wr_cnt + 1'b1);
            if (accept && win_done) stage_full <= 1'b1;
            else if (stage_take)    stage_full <= 1'b0;
        end
    end

    // NOTE: staging pixels carry no reset; only the flags qualifying them are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < BEAT_PIX; k++) begin
                // The beat's last pixel of the second half falls outside the window.
                if (col_base + k < WIN_DIM)
                    stage[PIX_W*(col_base + k + WIN_DIM*row_idx) +: PIX_W] <= in_bus.data[PIX_W*k +: PIX_W];
            end
        end
    end

    window_out_reg u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .stage_data (stage),
        .stage_full (stage_full),
        .stage_take (stage_take),
        .out_buffer (out_bus.data),
        .out_valid  (out_bus.valid),
        .out_ready  (out_bus.ready)
    );

    // Output windows are always whole, so no framing marker is needed downstream.
    assign out_bus.sof = 1'b0;
endmodule

// File: tb/tb_ref_window_loader.sv
// Randomized bench for ref_window_loader against a beat-list/window reference model.
module tb_ref_window_loader;
    import subpel_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic sof_err;
    always #5 clk = ~clk;

    ref_window_loader_if #(.W(BEAT_BITS)) in_bus ();
    ref_window_loader_if #(.W(WIN_BITS))  out_bus ();

    ref_window_loader dut (
        .clk     (clk),
        .rst     (rst),
        .in_bus  (in_bus),
        .out_bus (out_bus),
        .sof_err (sof_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Window from 30 beats: pixel(r,c) is byte c%8 of beat 2r + c/8.
    function automatic window_t build_win(input beat_t b [BEATS_PER_WIN]);
        window_t w = '0;
        beat_t   t;
        for (int r = 0; r < WIN_DIM; r++)
            for (int c = 0; c < WIN_DIM; c++) begin
                t = b[BEATS_PER_ROW*r + c/BEAT_PIX];
                w[PIX_W*(c + WIN_DIM*r) +: PIX_W] = t[PIX_W*(c%BEAT_PIX) +: PIX_W];
            end
        return w;
    endfunction

    function automatic window_t ramp_win();
        window_t w = '0;
        for (int r = 0; r < WIN_DIM; r++)
            for (int c = 0; c < WIN_DIM; c++)
                w[PIX_W*(c + WIN_DIM*r) +: PIX_W] = 8'(16*r + c);
        return w;
    endfunction

    function automatic beat_t ramp_beat(int i);
        beat_t b;
        for (int k = 0; k < BEAT_PIX; k++) b[PIX_W*k +: PIX_W] = 8'(16*(i/2) + 8*(i%2) + k);
        return b;
    endfunction

    task automatic check_win(string tag, window_t got, window_t exp);
        int r = 0;
        for (int i = WIN_DIM-1; i >= 0; i--)
            if (got[ROW_BITS*i +: ROW_BITS] !== exp[ROW_BITS*i +: ROW_BITS]) r = i;
        check(tag, 128'(got[ROW_BITS*r +: ROW_BITS]), 128'(exp[ROW_BITS*r +: ROW_BITS]));
    endtask

    // ---------------- reference model, advanced once per cycle ----------------
    beat_t   frame_q[$];
    window_t m_stage_win;
    window_t m_out_win;
    bit      m_stage, m_outv, m_err, m_acc, m_xfer, m_rel, m_new_err;
    bit      checking = 0;
    bit      prev_outv = 0;
    bit      prev_ready = 0;
    int      cyc = 0;
    int      last_done_cyc = 0;
    int      err_pulses = 0;
    int      rise_q[$];
    window_t got_win_q[$];

    function automatic window_t win_from_q();
        beat_t a [BEATS_PER_WIN];
        for (int i = 0; i < BEATS_PER_WIN; i++) a[i] = frame_q[i];
        return build_win(a);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (checking) begin
            check("in_ready",   128'(in_bus.ready),  128'(!rst && !m_stage));
            check("out_valid",  128'(out_bus.valid), 128'(m_outv));
            check("sof_err",    128'(sof_err),       128'(m_err));
            check_win("out_buffer", out_bus.data, m_out_win);
        end
        if (sof_err === 1'b1) err_pulses++;
        if (out_bus.valid === 1'b1 && !prev_outv) rise_q.push_back(cyc);
        if (out_bus.valid === 1'b1 && (!prev_outv || prev_ready)) got_win_q.push_back(out_bus.data);
        prev_outv  = (out_bus.valid === 1'b1);
        prev_ready = (out_bus.ready === 1'b1);

        if (rst === 1'b1) begin
            frame_q.delete();
            m_stage   = 0;
            m_outv    = 0;
            m_out_win = '0;
            m_err     = 0;
            checking  = 1;
        end else begin
            m_acc     = (in_bus.valid === 1'b1) && !m_stage;
            m_xfer    = m_stage && (!m_outv || out_bus.ready === 1'b1);
            m_rel     = m_outv && (out_bus.ready === 1'b1) && !m_stage;
            m_new_err = 0;
            if (m_acc) begin
                if (in_bus.sof === 1'b1 && frame_q.size() != 0) begin
                    m_new_err = 1;
                    frame_q.delete();
                end
                frame_q.push_back(in_bus.data);
                if (frame_q.size() == BEATS_PER_WIN) begin
                    m_stage_win   = win_from_q();
                    m_stage       = 1;
                    last_done_cyc = cyc;
                    frame_q.delete();
                end
            end
            if (m_xfer) begin
                m_out_win = m_stage_win;
                m_outv    = 1;
                m_stage   = 0;
            end else if (m_rel) begin
                m_outv = 0;
            end
            m_err = m_new_err;
        end
    end

    // ---------------- drivers ----------------
    beat_t win_beats [BEATS_PER_WIN];
    beat_t s_beats [4][BEATS_PER_WIN];

    task automatic send_beat(beat_t d, bit sof);
        bit took = 0;
        in_bus.valid = 1'b1;
        in_bus.data  = d;
        in_bus.sof   = sof;
        for (int i = 0; i < 200 && !took; i++) begin
            @(negedge clk);
            took = (in_bus.ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!took) check("accept_timeout", 128'(0), 128'(1));
        in_bus.valid = 1'b0;
        in_bus.sof   = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_win(bit stall, bit first_sof);
        for (int i = 0; i < BEATS_PER_WIN; i++) begin
            if (stall) idle(int'($urandom_range(0, 1)));
            send_beat(win_beats[i], first_sof && i == 0);
        end
    endtask

    task automatic rand_win();
        for (int i = 0; i < BEATS_PER_WIN; i++) win_beats[i] = {$urandom, $urandom};
    endtask

    task automatic wait_win(int n);
        for (int i = 0; i < 200 && got_win_q.size() < n; i++) @(negedge clk);
        check("window_timeout", 128'(got_win_q.size() >= n), 128'(1));
        @(posedge clk);
        #1;
    endtask

    window_t win_a, win_b, win_55;
    int      n0;

    initial begin
        rst           = 1'b1;
        in_bus.valid  = 1'b0;
        in_bus.data   = '0;
        in_bus.sof    = 1'b0;
        out_bus.ready = 1'b0;
        win_55        = {(WIN_DIM*WIN_DIM){8'h55}};
        idle(3);
        rst = 1'b0;
        check("reset_out_valid", 128'(out_bus.valid), 128'(0));
        check_win("reset_out_buffer", out_bus.data, '0);

        // 1: ramp at full rate
        out_bus.ready = 1'b1;
        for (int i = 0; i < BEATS_PER_WIN; i++) win_beats[i] = ramp_beat(i);
        got_win_q.delete();
        send_win(0, 1);
        wait_win(1);
        check_win("t1_ramp", got_win_q[0], ramp_win());
        check("t1_latency", 128'(rise_q[$] - last_done_cyc), 128'(2));
        idle(3);

        // 2: backpressure, window A held while B fills staging
        out_bus.ready = 1'b0;
        rand_win();
        win_a = build_win(win_beats);
        send_win(0, 1);
        rand_win();
        win_b = build_win(win_beats);
        send_win(0, 1);
        idle(3);
        check("t2_in_ready_blocked", 128'(in_bus.ready), 128'(0));
        check("t2_out_valid_held", 128'(out_bus.valid), 128'(1));
        check_win("t2_hold_a", out_bus.data, win_a);
        out_bus.ready = 1'b1;
        idle(1);
        out_bus.ready = 1'b0;
        check("t2_out_valid_b", 128'(out_bus.valid), 128'(1));
        check_win("t2_got_b", out_bus.data, win_b);
        idle(1);
        check("t2_in_ready_free", 128'(in_bus.ready), 128'(1));

        // 5: reset after beat 10 of a partial window
        for (int i = 0; i <= 10; i++) send_beat({$urandom, $urandom}, i == 0);
        rst = 1'b1;
        #1;
        check("t5_in_ready_rst", 128'(in_bus.ready), 128'(0));
        @(posedge clk);
        #1;
        check("t5_out_valid_rst", 128'(out_bus.valid), 128'(0));
        check_win("t5_out_buffer_rst", out_bus.data, '0);
        rst = 1'b0;
        out_bus.ready = 1'b1;
        rand_win();
        got_win_q.delete();
        send_win(0, 0);
        wait_win(1);
        check_win("t5_fresh", got_win_q[0], build_win(win_beats));
        idle(3);

        // 3: resync on beat 17
        err_pulses = 0;
        got_win_q.delete();
        for (int i = 0; i < 17; i++) send_beat({8{8'hAA}}, i == 0);
        for (int i = 0; i < BEATS_PER_WIN; i++) send_beat({8{8'h55}}, i == 0);
        wait_win(1);
        idle(2);
        check("t3_err_pulses", 128'(err_pulses), 128'(1));
        check_win("t3_all_55", got_win_q[0], win_55);
        check("t3_one_window", 128'(got_win_q.size()), 128'(1));

        // 4: ramp with random input stalls
        for (int i = 0; i < BEATS_PER_WIN; i++) win_beats[i] = ramp_beat(i);
        got_win_q.delete();
        send_win(1, 1);
        wait_win(1);
        check_win("t4_ramp_stalled", got_win_q[0], ramp_win());
        idle(3);

        // 6: four back-to-back windows
        got_win_q.delete();
        n0 = rise_q.size();
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < BEATS_PER_WIN; i++) s_beats[w][i] = {$urandom, $urandom};
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < BEATS_PER_WIN; i++) send_beat(s_beats[w][i], i == 0);
        wait_win(4);
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < BEATS_PER_WIN; i++) win_beats[i] = s_beats[w][i];
            if (got_win_q.size() > w) check_win($sformatf("t6_win%0d", w), got_win_q[w], build_win(win_beats));
        end
        check("t6_rises", 128'(rise_q.size() - n0), 128'(4));
        for (int i = 0; i < 3; i++)
            if (rise_q.size() >= n0 + i + 2)
                check($sformatf("t6_gap%0d", i), 128'(rise_q[n0+i+1] - rise_q[n0+i]), 128'(31));
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
